// File: rtl/strobe_channel_scheduler.sv
// Time-shared periodic strobe generator: one increment/compare datapath visits
// NUM_CH channels round-robin, one channel per clock.
module strobe_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  localparam int CH_BITS = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_BITS-1:0] cfg_ch,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic               cfg_enable,
  input  logic [NUM_CH-1:0]  ack,
  output logic [NUM_CH-1:0]  strobe,
  output logic [NUM_CH-1:0]  pending,
  output logic [NUM_CH-1:0]  overrun,
  output logic [CH_BITS-1:0] slot
);

  logic [CH_BITS-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]   period_q [NUM_CH];
  logic [WIDTH-1:0]   period_d [NUM_CH];
  logic [WIDTH-1:0]   cnt_q    [NUM_CH];
  logic [WIDTH-1:0]   cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [NUM_CH-1:0]  strobe_q, strobe_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  overrun_q, overrun_d;
  logic [NUM_CH-1:0]  cfg_sel, visit;
  logic               cfg_ready_q, cfg_ready_d;
  logic               cfg_fire;

  // Config handshake: a write transfers on cfg_valid && cfg_ready. cfg_ready is
  // a flop that drops for exactly one cycle after every transfer, so the
  // producer may hold cfg_valid high and the next write lands two clocks later.
  assign cfg_fire    = cfg_valid && cfg_ready_q;
  assign cfg_ready_d = !cfg_fire;

  always_comb begin
    slot_d = slot_q + CH_BITS'(1);
    if (slot_q == CH_BITS'(NUM_CH - 1)) begin
      slot_d = '0;
    end
  end

  always_comb begin
    cfg_sel  = '0;
    visit    = '0;
    strobe_d = '0;
    en_d     = en_q;
    for (int c = 0; c < NUM_CH; c++) begin
      period_d[c] = period_q[c];
      cnt_d[c]    = cnt_q[c];
      cfg_sel[c]  = cfg_fire && (cfg_ch == CH_BITS'(c));
      visit[c]    = (slot_q == CH_BITS'(c));
      // An accepted write overrides the visit of the same channel.
      if (cfg_sel[c]) begin
        period_d[c] = cfg_period;
        en_d[c]     = cfg_enable;
        cnt_d[c]    = WIDTH'(1);
      end else if (visit[c] && en_q[c] && (period_q[c] != '0)) begin
        if (cnt_q[c] == period_q[c]) begin
          cnt_d[c]    = WIDTH'(1);
          strobe_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end
      end
    end
    // Sticky flags: a new strobe beats an ack arriving on the same edge.
    pending_d = (pending_q & ~ack) | strobe_d;
    overrun_d = (overrun_q & ~ack) | (strobe_d & pending_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      en_q        <= '0;
      strobe_q    <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      cfg_ready_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        cnt_q[c]    <= WIDTH'(1);
      end
    end else begin
      slot_q      <= slot_d;
      en_q        <= en_d;
      strobe_q    <= strobe_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      cfg_ready_q <= cfg_ready_d;
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign strobe    = strobe_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_strobe_channel_scheduler.sv
// Directed bench for strobe_channel_scheduler: a cycle model fills an expected
// queue per driven cycle, plus directed timing checks on strobe/pending/overrun.
module tb_strobe_channel_scheduler;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 16;
  localparam int CH_BITS = 2;
  localparam int OW      = 1 + CH_BITS + 3 * NUM_CH;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_BITS-1:0] cfg_ch;
  logic [WIDTH-1:0]   cfg_period;
  logic               cfg_enable;
  logic [NUM_CH-1:0]  ack;
  logic [NUM_CH-1:0]  strobe;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  overrun;
  logic [CH_BITS-1:0] slot;

  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_t [NUM_CH];
  int ival   [NUM_CH];
  logic [NUM_CH-1:0] seen;

  logic [WIDTH-1:0]   m_period [NUM_CH];
  logic [WIDTH-1:0]   m_cnt    [NUM_CH];
  logic [NUM_CH-1:0]  m_en, m_strobe, m_pending, m_overrun;
  logic               m_ready;
  logic [CH_BITS-1:0] m_slot;

  strobe_channel_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_enable (cfg_enable),
    .ack        (ack),
    .strobe     (strobe),
    .pending    (pending),
    .overrun    (overrun),
    .slot       (slot)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_track();
    for (int c = 0; c < NUM_CH; c++) begin
      last_t[c] = -1;
      ival[c]   = 0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_period[c] = '0;
      m_cnt[c]    = 16'd1;
    end
    m_en      = '0;
    m_strobe  = '0;
    m_pending = '0;
    m_overrun = '0;
    m_ready   = 1'b1;
    m_slot    = '0;
    exp_q.delete();
    cyc = 0;
    clear_track();
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    logic              fire;
    logic [NUM_CH-1:0] st;
    logic [OW-1:0]     exp_v;
    fire = cfg_valid && m_ready;
    st   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire && cfg_ch == CH_BITS'(c)) begin
        m_period[c] = cfg_period;
        m_en[c]     = cfg_enable;
        m_cnt[c]    = 16'd1;
      end else if (m_slot == CH_BITS'(c) && m_en[c] && m_period[c] != 0) begin
        if (m_cnt[c] == m_period[c]) begin
          m_cnt[c] = 16'd1;
          st[c]    = 1'b1;
        end else begin
          m_cnt[c] = m_cnt[c] + 16'd1;
        end
      end
    end
    m_overrun = (m_overrun & ~ack) | (st & m_pending);
    m_pending = (m_pending & ~ack) | st;
    m_strobe  = st;
    m_ready   = !fire;
    m_slot    = (m_slot == CH_BITS'(NUM_CH - 1)) ? '0 : m_slot + 1'b1;
    exp_q.push_back({m_ready, m_slot, m_strobe, m_pending, m_overrun});
    @(posedge clk);
    #1;
    cyc++;
    exp_v = exp_q.pop_front();
    check("cycle", {cfg_ready, slot, strobe, pending, overrun}, exp_v);
    check("onehot", ($countones(strobe) <= 1), 1'b1);
    seen = seen | strobe;
    for (int c = 0; c < NUM_CH; c++) begin
      if (strobe[c]) begin
        if (last_t[c] >= 0) ival[c] = cyc - last_t[c];
        last_t[c] = cyc;
      end
    end
  endtask

  // driver: hold the write until it transfers; w = cycle index of the transfer
  task automatic cfg_write(input int ch, input int per, input logic en, output int w);
    int n;
    n          = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = CH_BITS'(ch);
    cfg_period = WIDTH'(per);
    cfg_enable = en;
    while (cfg_ready !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    check("cfg_accept_bound", (n < 4), 1'b1);
    w = cyc;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int ch, input int limit, output int t);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (strobe[ch] !== 1'b1 && n < limit);
    check("strobe_wait_bound", strobe[ch], 1'b1);
    t = cyc;
  endtask

  // first strobe cycle after a write at cycle w, for channel ch with period p
  function automatic int first_exp(input int ch, input int w, input int p);
    int d;
    d = (ch - (w % NUM_CH) + NUM_CH) % NUM_CH;
    if (d == 0) d = NUM_CH;
    return w + d + NUM_CH * (p - 1) + 1;
  endfunction

  initial begin
    int w, t1, t2, n;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_enable = 1'b0;
    ack        = '0;
    seen       = '0;
    model_reset();

    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", strobe, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_slot", slot, 0);
    check("rst_ready", cfg_ready, 1);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle_slot", slot, (i + 1) % NUM_CH);
      check("idle_ready", cfg_ready, 1);
    end
    check("idle_quiet", seen | pending | overrun, 0);

    // single channel, period 3
    seen = '0;
    cfg_write(0, 3, 1'b1, w);
    wait_strobe(0, 40, t1);
    check("ch0_first", t1, first_exp(0, w, 3));
    wait_strobe(0, 40, t2);
    check("ch0_interval", t2 - t1, 12);
    check("ch0_only", seen, 4'b0001);

    // mixed periods
    cfg_write(1, 1, 1'b1, w);
    cfg_write(2, 2, 1'b1, w);
    cfg_write(3, 5, 1'b1, w);
    clear_track();
    repeat (60) tick();
    check("mix_ival0", ival[0], 12);
    check("mix_ival1", ival[1], 4);
    check("mix_ival2", ival[2], 8);
    check("mix_ival3", ival[3], 20);

    // back-to-back writes with cfg_valid held high
    clear_track();
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd3;
    cfg_period = 16'd4;
    cfg_enable = 1'b1;
    check("hs_ready_a", cfg_ready, 1);
    tick();
    cfg_ch     = 2'd1;
    cfg_period = 16'd2;
    check("hs_ready_b", cfg_ready, 0);
    tick();
    check("hs_ready_c", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    repeat (50) tick();
    check("hs_ival3", ival[3], 16);
    check("hs_ival1", ival[1], 8);

    // write to ch2 in the cycle its slot is visited
    cfg_write(2, 1, 1'b1, w);
    n = 0;
    while ((cyc % NUM_CH != 2 || cfg_ready !== 1'b1) && n < 8) begin
      tick();
      n++;
    end
    cfg_write(2, 3, 1'b1, w);
    check("coll_no_strobe", strobe[2], 0);
    wait_strobe(2, 40, t1);
    check("coll_restart", t1, first_exp(2, w, 3));

    // pending / overrun
    cfg_write(1, 0, 1'b0, w);
    cfg_write(2, 0, 1'b0, w);
    cfg_write(3, 0, 1'b0, w);
    cfg_write(0, 1, 1'b1, w);
    repeat (4) tick();
    n = 0;
    while (cyc % NUM_CH != 1 && n < 8) begin
      tick();
      n++;
    end
    ack = 4'hf;
    tick();
    ack = '0;
    check("ack_all_pending", pending, 0);
    check("ack_all_overrun", overrun, 0);
    wait_strobe(0, 8, t1);
    check("pend_first", pending[0], 1);
    check("ovr_first", overrun[0], 0);
    wait_strobe(0, 8, t1);
    check("pend_second", pending[0], 1);
    check("ovr_second", overrun[0], 1);
    ack = 4'b0001;
    tick();
    ack = '0;
    check("ack_quiet_pending", pending[0], 0);
    check("ack_quiet_overrun", overrun[0], 0);
    wait_strobe(0, 8, t1);
    wait_strobe(0, 8, t1);
    n = 0;
    while (cyc % NUM_CH != 0 && n < 8) begin
      tick();
      n++;
    end
    ack = 4'b0001;
    tick();
    ack = '0;
    check("ack_set_strobe", strobe[0], 1);
    check("ack_set_pending", pending[0], 1);
    check("ack_set_overrun", overrun[0], 1);

    // asynchronous reset mid-cycle while a strobe is high
    wait_strobe(0, 8, t1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_strobe", strobe, 0);
    check("arst_pending", pending, 0);
    check("arst_overrun", overrun, 0);
    check("arst_slot", slot, 0);
    check("arst_ready", cfg_ready, 1);
    @(posedge clk);
    #4 rst_n = 1'b1;
    seen = '0;
    repeat (40) tick();
    check("arst_quiet", seen | pending | overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
